// File: rtl/v2f_alu_pkg.sv
// Shared opcode definitions and defaults for the two-stage ALU pipeline.
package v2f_alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_MOD   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHRA  = 4'd9;
  localparam logic [3:0] OP_SHRL  = 4'd10;
  localparam logic [3:0] OP_LT    = 4'd11;
  localparam logic [3:0] OP_GT    = 4'd12;
  localparam logic [3:0] OP_EQ    = 4'd13;
  localparam logic [3:0] OP_NE    = 4'd14;
  localparam logic [3:0] OP_PASSB = 4'd15;

  typedef enum logic [3:0] {
    ALU_ADD   = OP_ADD,
    ALU_SUB   = OP_SUB,
    ALU_MUL   = OP_MUL,
    ALU_DIV   = OP_DIV,
    ALU_MOD   = OP_MOD,
    ALU_AND   = OP_AND,
    ALU_OR    = OP_OR,
    ALU_XOR   = OP_XOR,
    ALU_SHL   = OP_SHL,
    ALU_SHRA  = OP_SHRA,
    ALU_SHRL  = OP_SHRL,
    ALU_LT    = OP_LT,
    ALU_GT    = OP_GT,
    ALU_EQ    = OP_EQ,
    ALU_NE    = OP_NE,
    ALU_PASSB = OP_PASSB
  } alu_op_e;

endpackage

// File: rtl/v2f_pipe_reg.sv
// Valid/ready register slice; payload is cleared on reset so outputs start at zero.
module v2f_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/v2f_alu_pipe.sv
// Two-stage signed ALU: S1 holds the operation, S2 holds result/tag/dz.
module v2f_alu_pipe
  import v2f_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz,
  output logic             err_sticky,
  input  logic             err_clr
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int P1_W = 4 + 2 * WIDTH + TAG_W;
  localparam int P2_W = WIDTH + TAG_W + 1;

  logic             s1_valid;
  logic             s1_ready;
  logic             s2_ready;
  logic [P1_W-1:0]  s1_data;
  logic [P2_W-1:0]  s2_in;
  logic [P2_W-1:0]  s2_data;

  logic [3:0]       op_raw;
  alu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] tag;
  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;
  logic [SH_W-1:0]  sh;
  logic             b_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] y;
  logic             dz;
  logic             dz_loaded;

  v2f_pipe_reg #(.W(P1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s1_ready),
    .in_data   ({in_op, in_a, in_b, in_tag}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign in_ready = s1_ready;

  assign {op_raw, a, b, tag} = s1_data;
  assign op      = alu_op_e'(op_raw);
  assign sa      = a;
  assign sb      = b;
  assign sh      = b[SH_W-1:0];
  assign b_zero  = (b == '0);
  // MIN / -1 overflows; pin the quotient to MIN and the remainder to 0
  assign div_ovf = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  always_comb begin
    y  = '0;
    dz = 1'b0;
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_MUL:   y = a * b;
      ALU_DIV: begin
        if (b_zero)       dz = 1'b1;
        else if (div_ovf) y  = a;
        else              y  = sa / sb;
      end
      ALU_MOD: begin
        if (b_zero)       dz = 1'b1;
        else if (div_ovf) y  = '0;
        else              y  = sa % sb;
      end
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SHL:   y = a << sh;
      ALU_SHRA:  y = sa >>> sh;
      ALU_SHRL:  y = a >> sh;
      ALU_LT:    y = {{(WIDTH-1){1'b0}}, sa < sb};
      ALU_GT:    y = {{(WIDTH-1){1'b0}}, sa > sb};
      ALU_EQ:    y = {{(WIDTH-1){1'b0}}, a == b};
      ALU_NE:    y = {{(WIDTH-1){1'b0}}, a != b};
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

  assign s2_in = {y, tag, dz};

  v2f_pipe_reg #(.W(P2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign {out_y, out_tag, out_dz} = s2_data;

  // dz_loaded pulses for the one cycle after S2 takes a dz result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_loaded  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      dz_loaded <= s1_valid && s2_ready && dz;
      if (dz_loaded)    err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

endmodule
